// File: rtl/complex_pkg.sv
// Shared definitions for the complex sign-manipulation datapath: op encodings
// and the saturating negate used by every lane.
package complex_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CALC_W    = 64;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_CONJ  = 2'd1,
    MODE_NEG   = 2'd2,
    MODE_MULNJ = 2'd3
  } mode_e;

  typedef struct packed {
    logic signed [CALC_W-1:0] val;
    logic                     clip;
  } neg_t;

  // Negates a sign-extended w-bit value; the single unrepresentable case
  // (-2^(w-1)) is clipped to the w-bit maximum and flagged.
  function automatic neg_t sat_neg(input logic signed [CALC_W-1:0] x,
                                   input int unsigned w);
    neg_t r;
    logic signed [CALC_W-1:0] lo;
    lo = '1;
    lo = lo << (w - 1);
    if (x == lo) begin
      r.val  = ~lo;
      r.clip = 1'b1;
    end else begin
      r.val  = -x;
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/complex_conj_lane.sv
// One complex lane: pass / conjugate / negate / multiply by -j, with
// saturating negation and a per-lane clip flag. Purely combinational.
module complex_conj_lane
  import complex_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  mode_e                   mode,
  output logic signed [WIDTH-1:0] y_re,
  output logic signed [WIDTH-1:0] y_im,
  output logic                    sat
);

  neg_t na;
  neg_t nb;
  logic unused_hi;

  always_comb begin
    na   = sat_neg(CALC_W'(a), WIDTH);
    nb   = sat_neg(CALC_W'(b), WIDTH);
    y_re = a;
    y_im = b;
    sat  = 1'b0;
    case (mode)
      MODE_CONJ: begin
        y_im = nb.val[WIDTH-1:0];
        sat  = nb.clip;
      end
      MODE_NEG: begin
        y_re = na.val[WIDTH-1:0];
        y_im = nb.val[WIDTH-1:0];
        sat  = na.clip | nb.clip;
      end
      // (a + jb) * -j = b - ja
      MODE_MULNJ: begin
        y_re = b;
        y_im = na.val[WIDTH-1:0];
        sat  = na.clip;
      end
      default: ;
    endcase
  end

  // Upper bits of the wide negate are just sign extension of the clamped result.
  assign unused_hi = ^{na.val[CALC_W-1:WIDTH], nb.val[CALC_W-1:WIDTH]};

endmodule

// File: rtl/complex_conj_pipe.sv
// Multi-lane complex sign stage: NUM_CH lanes, output register plus one skid
// register on a valid/ready handshake, and a sticky saturation-event counter.
module complex_conj_pipe
  import complex_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_real,
  input  logic [NUM_CH*WIDTH-1:0] in_imag,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_real,
  output logic [NUM_CH*WIDTH-1:0] out_imag,
  output logic [NUM_CH-1:0]       out_sat,
  input  logic                    sat_clr,
  output logic [CNT_W-1:0]        sat_count
);

  logic [NUM_CH*WIDTH-1:0] re_p0, im_p0;
  logic [NUM_CH-1:0]       sat_p0;
  logic [NUM_CH*WIDTH-1:0] skid_re_p1, skid_im_p1;
  logic [NUM_CH-1:0]       skid_sat_p1;
  logic                    vld_p1;
  logic [NUM_CH*WIDTH-1:0] re_p2, im_p2;
  logic [NUM_CH-1:0]       sat_p2;
  logic                    vld_p2;
  logic [CNT_W-1:0]        cnt;
  logic                    accept, load_out;

  // ---- stage p0: combinational lane ops on the incoming beat ----
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    complex_conj_lane #(.WIDTH(WIDTH)) u_lane (
      .a    (in_real[k*WIDTH +: WIDTH]),
      .b    (in_imag[k*WIDTH +: WIDTH]),
      .mode (mode_e'(in_mode)),
      .y_re (re_p0[k*WIDTH +: WIDTH]),
      .y_im (im_p0[k*WIDTH +: WIDTH]),
      .sat  (sat_p0[k])
    );
  end

  assign in_ready = ~vld_p1;
  assign accept   = in_valid & in_ready;
  // Output register can take a beat when empty or being drained this cycle.
  assign load_out = ~vld_p2 | out_ready;

  // ---- stage p1: skid register, filled only when the output reg is stalled ----
  always_ff @(posedge clk) begin
    if (accept && !load_out) begin
      skid_re_p1  <= re_p0;
      skid_im_p1  <= im_p0;
      skid_sat_p1 <= sat_p0;
    end
  end

  // ---- stage p2: output register; skid has priority so order is preserved ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      re_p2  <= '0;
      im_p2  <= '0;
      sat_p2 <= '0;
    end else if (load_out) begin
      if (vld_p1) begin
        re_p2  <= skid_re_p1;
        im_p2  <= skid_im_p1;
        sat_p2 <= skid_sat_p1;
        vld_p2 <= 1'b1;
        vld_p1 <= 1'b0;
      end else if (accept) begin
        re_p2  <= re_p0;
        im_p2  <= im_p0;
        sat_p2 <= sat_p0;
        vld_p2 <= 1'b1;
      end else begin
        vld_p2 <= 1'b0;
      end
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end
  end

  // Counted at accept time; a clear in the same cycle discards the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sat_clr) begin
      cnt <= '0;
    end else if (accept && (|sat_p0) && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_valid = vld_p2;
  assign out_real  = re_p2;
  assign out_imag  = im_p2;
  assign out_sat   = sat_p2;
  assign sat_count = cnt;

endmodule
